// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - word-in / bit-out handshake bundle for piso_serializer
interface piso_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             serial_o;
  logic             first_o;
  logic             last_o;
  logic             busy_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, serial_o, first_o, last_o, busy_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, serial_o, first_o, last_o, busy_o
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out shifter with valid/ready on both sides
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  piso_serializer_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("piso_serializer: WIDTH must be in 2..64");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             valid_r;
  logic             first_r;
  logic             last_r;
  logic             accept;
  logic             beat;
  logic             out_bit;
  logic [WIDTH-1:0] sr_shifted;

  // Ready also opens on the last beat so the next word loads with no bubble.
  assign bus.in_ready_o = (state == IDLE) || (valid_r && bus.out_ready_i && last_r);
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign beat           = valid_r && bus.out_ready_i;

  assign out_bit    = LSB_FIRST ? sr[0] : sr[WIDTH-1];
  assign sr_shifted = LSB_FIRST ? (sr >> 1) : (sr << 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (accept) begin
      state   <= SHIFT;
      sr      <= bus.in_data_i;
      cnt     <= '0;
      valid_r <= 1'b1;
      first_r <= 1'b1;
      last_r  <= 1'b0;
    end else if (beat) begin
      sr      <= sr_shifted;
      first_r <= 1'b0;
      if (cnt == LAST_IDX) begin
        state   <= IDLE;
        cnt     <= '0;
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end else begin
        cnt    <= cnt + CW'(1);
        last_r <= (cnt == PRE_LAST);
      end
    end
  end

  assign bus.out_valid_o = valid_r;
  assign bus.busy_o      = valid_r;
  assign bus.serial_o    = valid_r & out_bit;
  assign bus.first_o     = first_r;
  assign bus.last_o      = last_r;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (LSB/MSB width 8, width 2)
module tb_piso_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) if_l ();
  piso_serializer_if #(.WIDTH(8)) if_m ();
  piso_serializer_if #(.WIDTH(2)) if_2 ();

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l (.clk(clk), .reset(reset), .bus(if_l));
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m (.clk(clk), .reset(reset), .bus(if_m));
  piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b1)) u_2 (.clk(clk), .reset(reset), .bus(if_2));

  // entries are {serial, first, last}
  logic [2:0] q_l[$];
  logic [2:0] q_m[$];
  logic [2:0] q_2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // seq[w-1] is the first bit expected on the wire; only the first n beats are queued
  task automatic push(input int which, input logic [7:0] seq, input int w, input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      e = {seq[w-1-i], (i == 0), (i == w-1)};
      case (which)
        0: q_l.push_back(e);
        1: q_m.push_back(e);
        default: q_2.push_back(e);
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (!reset && if_l.out_valid_o && if_l.out_ready_i) begin
      chk("l_busy", if_l.busy_o, if_l.out_valid_o);
      if (q_l.size() == 0) chk("l_unexpected_beat", 1, 0);
      else chk("l_beat", {if_l.serial_o, if_l.first_o, if_l.last_o}, q_l.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && if_m.out_valid_o && if_m.out_ready_i) begin
      if (q_m.size() == 0) chk("m_unexpected_beat", 1, 0);
      else chk("m_beat", {if_m.serial_o, if_m.first_o, if_m.last_o}, q_m.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && if_2.out_valid_o && if_2.out_ready_i) begin
      if (q_2.size() == 0) chk("w2_unexpected_beat", 1, 0);
      else chk("w2_beat", {if_2.serial_o, if_2.first_o, if_2.last_o}, q_2.pop_front());
    end
  end

  task automatic send_l(input logic [7:0] d);
    if_l.in_valid_i = 1'b1;
    if_l.in_data_i  = d;
    @(posedge clk); #1;
    if_l.in_valid_i = 1'b0;
  endtask

  task automatic send_m(input logic [7:0] d);
    if_m.in_valid_i = 1'b1;
    if_m.in_data_i  = d;
    @(posedge clk); #1;
    if_m.in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    int acc_c[2];
    if_l.in_valid_i = 0; if_l.in_data_i = '0; if_l.out_ready_i = 1;
    if_m.in_valid_i = 0; if_m.in_data_i = '0; if_m.out_ready_i = 1;
    if_2.in_valid_i = 0; if_2.in_data_i = '0; if_2.out_ready_i = 1;

    #2 reset = 1'b1;
    #1;
    chk("rst_in_ready", if_l.in_ready_o, 1);
    chk("rst_outs", {if_l.out_valid_o, if_l.serial_o, if_l.first_o, if_l.last_o, if_l.busy_o}, 0);
    chk("rst_cnt", u_l.cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // LSB-first 8'hA5: wire order 1,0,1,0,0,1,0,1
    push(0, 8'b10100101, 8, 8);
    send_l(8'hA5);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("a5_in_ready_b%0d", b), if_l.in_ready_o, (b == 7));
      @(posedge clk); #1;
    end
    chk("a5_idle_after", if_l.out_valid_o, 0);

    // MSB-first 8'hA5 then 8'h01 (seven zeros then a one)
    push(1, 8'b10100101, 8, 8);
    send_m(8'hA5);
    repeat (7) @(posedge clk); #1;
    push(1, 8'b00000001, 8, 8);
    send_m(8'h01);
    repeat (8) @(posedge clk); #1;
    chk("m_idle_after", if_m.out_valid_o, 0);

    // backpressure on 8'hC3: wire order 1,1,0,0,0,0,1,1, stall 5 cycles with beat 3 presented
    push(0, 8'b11000011, 8, 8);
    send_l(8'hC3);
    repeat (3) @(posedge clk); #1;
    if_l.out_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      chk("stall_outs", {if_l.out_valid_o, if_l.serial_o, if_l.first_o, if_l.last_o}, 4'b1000);
      chk("stall_cnt", u_l.cnt, 3);
      chk("stall_in_ready", if_l.in_ready_o, 0);
    end
    if_l.out_ready_i = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("stall_idle_after", if_l.out_valid_o, 0);

    // back-to-back 8'hFF then 8'h00 with in_valid held high
    push(0, 8'hFF, 8, 8);
    push(0, 8'h00, 8, 8);
    acc_n = 0;
    acc_c[0] = -1; acc_c[1] = -1;
    if_l.in_valid_i = 1'b1;
    if_l.in_data_i  = 8'hFF;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k >= 1) chk($sformatf("b2b_valid_k%0d", k), if_l.out_valid_o, 1);
      if (if_l.in_valid_i && if_l.in_ready_o && acc_n < 2) begin
        acc_c[acc_n] = k;
        acc_n++;
      end
      @(posedge clk); #1;
      if (acc_n >= 1) if_l.in_data_i = 8'h00;
      if (acc_n == 2) if_l.in_valid_i = 1'b0;
    end
    chk("b2b_accept0", acc_c[0], 0);
    chk("b2b_accept1", acc_c[1], 8);
    chk("b2b_idle_after", if_l.out_valid_o, 0);

    // reset while beat 3 of 8'h5A is presented; bits 0..2 = 0,1,0 make it out first
    push(0, 8'b01011010, 8, 3);
    send_l(8'h5A);
    repeat (3) @(posedge clk); #1;
    chk("mid_cnt_before_rst", u_l.cnt, 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {if_l.out_valid_o, if_l.serial_o, if_l.in_ready_o}, 3'b001);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_rst_idle", if_l.out_valid_o, 0);
    push(0, 8'b10000001, 8, 8);
    send_l(8'h81);
    chk("post_rst_first", {if_l.first_o, if_l.serial_o}, 2'b11);
    repeat (8) @(posedge clk); #1;

    // WIDTH=2: 2'b10 then 2'b01 back-to-back, wire order 0,1,1,0
    push(2, 8'b01, 2, 2);
    push(2, 8'b10, 2, 2);
    acc_n = 0;
    if_2.in_valid_i = 1'b1;
    if_2.in_data_i  = 2'b10;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 4) chk($sformatf("w2_in_ready_k%0d", k), if_2.in_ready_o, (k % 2 == 0));
      if (if_2.in_valid_i && if_2.in_ready_o && acc_n < 2) acc_n++;
      @(posedge clk); #1;
      if (acc_n >= 1) if_2.in_data_i = 2'b01;
      if (acc_n == 2) if_2.in_valid_i = 1'b0;
    end
    chk("w2_accepts", acc_n, 2);
    chk("w2_idle_after", if_2.out_valid_o, 0);

    chk("q_l_drained", q_l.size(), 0);
    chk("q_m_drained", q_m.size(), 0);
    chk("q_2_drained", q_2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
